inst_sram_ctrl: RTL and testbench
=================================

Name: inst_sram_ctrl

Overview:
Instruction-memory responder that serves the fetch stage's im_addr/im_data interface from an external asynchronous SRAM.
- Holds a one-entry fetch latch (last address plus its data) so that a repeated address returns immediately.
- Runs a multi-cycle SRAM read on a miss and raises im_stall, which drives the fetch stage's if_bubble, until the data is latched.
- Returns a NOP and flags im_fault for addresses outside the SRAM window or misaligned addresses.

Parameters:
- WAIT_CYCLES, 2, SRAM read cycles per access (legal range 1..15).
- ADDR_W, 20, SRAM word-address width.
- BASE, 32'h80000000, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- im_addr  in  32  fetch byte address; may change on any clk edge.
- im_inval  in  1  clears the fetch latch (used after code writes).
- im_data  out  32  instruction for im_addr; combinational.
- im_stall  out  1  high means im_data is not valid for im_addr; combinational; drives if_bubble.
- im_fault  out  1  im_addr out of window or misaligned; combinational.
- sram_addr  out  ADDR_W  SRAM word address; registered.
- sram_data  in  32  SRAM read data.
- sram_ce_n  out  1  chip enable, active low; registered.
- sram_oe_n  out  1  output enable, active low; registered.
- sram_we_n  out  1  write enable; held at 1 (read-only block).
- sram_be_n  out  4  byte enables; held at 4'b0000.

Behaviour:
- Window check:
  - legal = (im_addr[1:0]==0) && BASE <= im_addr < BASE + 4*2^ADDR_W.
  - The default window is 0x80000000..0x803FFFFF.
  - Word index = (im_addr - BASE)[ADDR_W+1:2].
- Fault, when legal==0:
  - im_fault=1, im_data=32'h00000000, im_stall=0.
  - No SRAM access is started.
  - The latch and FSM are unaffected.
- Hit: legal && valid && im_addr==tag && state==IDLE gives im_stall=0, im_fault=0, im_data=data_q.
- Otherwise (legal, not hit): im_stall=1, im_data=data_q (undefined for the fetch stage).
- FSM states: IDLE, READ.
  - IDLE → READ on a legal miss. In the same edge:
    - req_tag<=im_addr;
    - sram_addr<=word index;
    - sram_ce_n<=0; sram_oe_n<=0;
    - cnt<=WAIT_CYCLES-1.
  - READ with cnt!=0: cnt<=cnt-1.
  - READ with cnt==0, leaving READ → IDLE:
    - data_q<=sram_data; tag<=req_tag; valid<=1;
    - sram_ce_n<=1; sram_oe_n<=1.
- Latency:
  - A miss first presented in cycle T is a hit in cycle T+WAIT_CYCLES+1.
  - im_stall is high for exactly WAIT_CYCLES+1 cycles when im_addr is held.
- im_addr changing during READ:
  - The read completes for req_tag. There is no abort.
  - The new address misses in IDLE and starts a fresh read, so stall stays continuous.
- im_inval:
  - valid<=0 on the next edge.
  - If asserted in the completing READ cycle, inval wins: data_q is updated but valid stays 0.
  - im_inval does not abort a read in progress.
- Back-to-back: a legal miss arriving in the IDLE cycle immediately after completion starts the next read in that same cycle. There is no dead cycle.
- Reset (any cycle, including mid-READ), effective from the next edge:
  - state=IDLE, valid=0, tag=0, data_q=0, cnt=0;
  - sram_addr=0, sram_ce_n=1, sram_oe_n=1.
  - sram_we_n=1 and sram_be_n=4'b0000 always.
  - After reset, im_stall follows the combinational rules; the fetch stage's initial address 0xFFFFFFFF gives im_fault=1, im_data=0, im_stall=0.
- SRAM timing:
  - sram_addr, sram_ce_n and sram_oe_n are stable for the whole READ.
  - sram_data is sampled only on the final READ edge.

Test Plan:
1. Fault at reset:
   - Stimulus: rst high 2 cycles, then low with im_addr=0xFFFFFFFF.
   - Required: im_fault=1, im_data=0, im_stall=0, sram_ce_n=1 throughout.
2. Miss then hit (WAIT_CYCLES=2):
   - Stimulus: im_addr=0x80000000, SRAM word 0=0x3C010001.
   - Required: im_stall=1 for 3 cycles and sram_addr=0 with ce_n/oe_n low during READ; then im_stall=0 and im_data=0x3C010001 while held.
3. Sequential fetch:
   - Stimulus: 0x80000000, then 0x80000004 after the hit.
   - Required: second read drives sram_addr=1, stall 3 cycles, im_data = word 1.
4. Address change mid-READ:
   - Stimulus: switch im_addr 0x80000008→0x80000100 one cycle into READ.
   - Required: the first read completes with tag=0x80000008; a second read with sram_addr=0x40 follows at once; im_stall stays continuously high until word 0x40 is a hit.
5. Invalidate:
   - Stimulus: hit on 0x80000000; pulse im_inval; separately pulse im_inval in the completing cycle.
   - Required: after each pulse the same address misses again (stall 3 cycles).
6. Reset and misalignment:
   - Stimulus: assert rst in the 2nd READ cycle.
   - Required: ce_n/oe_n=1 on the next edge; after rst release, the previously requested address misses.
   - Stimulus: im_addr=0x80000002 or 0x80400000.
   - Required: im_fault=1, im_data=0, im_stall=0, no SRAM access.

Source files
------------

// File: rtl/inst_sram_ctrl.sv
// Fetch-side instruction responder: one-entry address/data latch in front of an async SRAM.
// Hits and faults answer combinationally; a legal miss stalls for WAIT_CYCLES+1 cycles.
module inst_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20,
  parameter logic [31:0] BASE        = 32'h80000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       im_addr_i,
  input  logic              im_inval_i,
  output logic [31:0]       im_data_o,
  output logic              im_stall_o,
  output logic              im_fault_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  typedef enum logic {IDLE, READ} state_e;

  localparam logic [32:0] WIN_SIZE = 33'd1 << (ADDR_W + 2);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [31:0]       tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       req_tag_q, req_tag_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;

  logic [32:0] off;
  logic        legal;
  logic        hit;

  // Addresses below BASE wrap to a huge 33-bit offset and fail the size test.
  assign off   = {1'b0, im_addr_i} - {1'b0, BASE};
  assign legal = (im_addr_i[1:0] == 2'b00) && (off < WIN_SIZE);
  assign hit   = legal && valid_q && (im_addr_i == tag_q) && (state_q == IDLE);

  assign im_fault_o  = ~legal;
  assign im_stall_o  = legal && ~hit;
  assign im_data_o   = legal ? data_q : 32'h00000000;

  assign sram_addr_o = sram_addr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = 1'b1;
  assign sram_be_n_o = 4'b0000;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    req_tag_d   = req_tag_q;
    sram_addr_d = sram_addr_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;

    if (im_inval_i) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (legal && ~hit) begin
          state_d     = READ;
          req_tag_d   = im_addr_i;
          sram_addr_d = off[ADDR_W+1:2];
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b0;
          cnt_d       = CNT_INIT;
        end
      end
      READ: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Data still lands on an invalidate; only the valid bit is held off.
          state_d = IDLE;
          data_d  = sram_data_i;
          tag_d   = req_tag_q;
          valid_d = ~im_inval_i;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      valid_q     <= 1'b0;
      tag_q       <= 32'h0;
      data_q      <= 32'h0;
      req_tag_q   <= 32'h0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      req_tag_q   <= req_tag_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Directed bench for inst_sram_ctrl with a behavioural async SRAM and an expected-data queue.
module tb_inst_sram_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] im_addr;
  logic        im_inval;
  logic [31:0] im_data;
  logic        im_stall;
  logic        im_fault;
  logic [19:0] sram_addr;
  logic [31:0] sram_data;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  inst_sram_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .im_addr_i   (im_addr),
    .im_inval_i  (im_inval),
    .im_data_o   (im_data),
    .im_stall_o  (im_stall),
    .im_fault_o  (im_fault),
    .sram_addr_o (sram_addr),
    .sram_data_i (sram_data),
    .sram_ce_n_o (sram_ce_n),
    .sram_oe_n_o (sram_oe_n),
    .sram_we_n_o (sram_we_n),
    .sram_be_n_o (sram_be_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [19:0] w);
    if (w == 20'd0) return 32'h3C010001;
    return 32'h0C000000 + {12'h0, w} * 32'd7;
  endfunction

  function automatic logic [19:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'h80000000;
    return o[21:2];
  endfunction

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem(sram_addr) : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present address a; optionally switch to a2 or pulse im_inval at a given stall cycle.
  task automatic fetch(input logic [31:0] a, input int exp_stall, input int inval_at,
                       input logic [31:0] a2, input int switch_at);
    int n;
    logic [31:0] d;
    im_addr = a;
    sb.push_back(mem(widx(switch_at >= 0 ? a2 : a)));
    #1;
    n = 0;
    while (im_stall && n < 40) begin
      if (n % 3 == 0) begin
        chk("idle_ce_n", 32'(sram_ce_n), 32'd1);
      end else begin
        chk("read_ce_n", 32'(sram_ce_n), 32'd0);
        chk("read_oe_n", 32'(sram_oe_n), 32'd0);
        chk("read_addr", 32'(sram_addr), 32'(n < 3 ? widx(a) : widx(im_addr)));
      end
      im_inval = (n == inval_at);
      if (n == switch_at) im_addr = a2;
      n++;
      @(negedge clk);
    end
    im_inval = 1'b0;
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    d = sb.pop_front();
    chk("hit_data", im_data, d);
    chk("hit_fault", 32'(im_fault), 32'd0);
  endtask

  task automatic fault_chk(input logic [31:0] a);
    im_addr = a;
    #1;
    chk("fault", 32'(im_fault), 32'd1);
    chk("fault_data", im_data, 32'h0);
    chk("fault_stall", 32'(im_stall), 32'd0);
    @(negedge clk);
    chk("fault_ce_n", 32'(sram_ce_n), 32'd1);
    chk("fault_stall2", 32'(im_stall), 32'd0);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    im_addr  = 32'hFFFFFFFF;
    im_inval = 1'b0;

    // reset with fetch stage's initial address
    @(negedge clk);
    chk("rst_fault", 32'(im_fault), 32'd1);
    chk("rst_data", im_data, 32'h0);
    chk("rst_stall", 32'(im_stall), 32'd0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("we_n", 32'(sram_we_n), 32'd1);
    chk("be_n", 32'(sram_be_n), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fault", 32'(im_fault), 32'd1);
    chk("post_rst_stall", 32'(im_stall), 32'd0);
    chk("post_rst_ce_n", 32'(sram_ce_n), 32'd1);

    // miss then held hits
    fetch(32'h80000000, 3, -1, 32'h0, -1);
    @(negedge clk);
    fetch(32'h80000000, 0, -1, 32'h0, -1);
    @(negedge clk);
    fetch(32'h80000000, 0, -1, 32'h0, -1);

    // sequential fetch
    fetch(32'h80000004, 3, -1, 32'h0, -1);

    // address change one cycle into READ: continuous stall across both reads
    fetch(32'h80000008, 6, -1, 32'h80000100, 1);
    fetch(32'h80000100, 0, -1, 32'h0, -1);

    // invalidate on a hit
    fetch(32'h80000000, 3, -1, 32'h0, -1);
    im_inval = 1'b1;
    #1;
    chk("inval_cycle_hit", 32'(im_stall), 32'd0);
    @(negedge clk);
    im_inval = 1'b0;
    fetch(32'h80000000, 3, -1, 32'h0, -1);

    // invalidate in the completing READ cycle forces a second read
    im_inval = 1'b1;
    @(negedge clk);
    im_inval = 1'b0;
    fetch(32'h80000000, 6, 2, 32'h0, -1);
    fetch(32'h80000000, 0, -1, 32'h0, -1);

    // faults leave the latch intact
    fault_chk(32'h80000002);
    fault_chk(32'h80400000);
    fault_chk(32'h7FFFFFFC);
    fault_chk(32'hFFFFFFFF);
    fetch(32'h80000000, 0, -1, 32'h0, -1);
    fetch(32'h803FFFFC, 3, -1, 32'h0, -1);

    // reset during the final READ cycle
    im_addr = 32'h80000010;
    #1;
    chk("pre_rst_stall", 32'(im_stall), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("midrst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    chk("midrst_data", im_data, 32'h0);
    rst = 1'b0;
    fetch(32'h80000010, 3, -1, 32'h0, -1);
    fetch(32'h803FFFFC, 3, -1, 32'h0, -1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
